ibex_prefetch_buffer_nreq: RTL

IBEX_PREFETCH_BUFFER_NREQ -- requirements
Module: ibex_prefetch_buffer_nreq

---
 rtl/ibex_prefetch_buffer_nreq.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/ibex_prefetch_buffer_nreq.sv
// Instruction prefetch buffer with up to NumReqs outstanding bus requests,
// in-order discard tracking for redirects and a FifoDepth-entry output FIFO.
module ibex_prefetch_buffer_nreq #(
  parameter int unsigned NumReqs   = 2,
  parameter int unsigned FifoDepth = 3,
  parameter bit          ResetAll  = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        prefetch_en_i,

  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,

  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  input  logic        instr_rvalid_i,

  output logic        busy_o,
  output logic [2:0]  outstanding_o
);

  localparam int unsigned OutW = 3;
  localparam int unsigned CntW = 4;
  localparam int unsigned SumW = 5;
  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] addr;
  } fifo_entry_t;

  logic                run_q;
  logic                hold_q, hold_d;
  logic                hold_disc_q, hold_disc_d;
  logic [31:0]         hold_addr_q, hold_addr_d;
  logic [31:0]         fetch_addr_q, fetch_addr_d;
  logic [31:0]         rsp_addr_q, rsp_addr_d;
  logic [OutW-1:0]     out_cnt_q, out_cnt_d;
  logic [NumReqs-1:0]  disc_q, disc_d;
  logic [CntW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  fifo_entry_t         mem_q [FifoDepth];

  logic [31:0]         target;
  logic [OutW-1:0]     nd_out;
  logic [OutW-1:0]     push_idx;
  logic                space_ok;
  logic                single_ok;
  logic                new_req;
  logic                cur_tag;
  logic                gnt;
  logic                rsp_pop;
  logic                rsp_accept;
  logic                fifo_pop;
  logic                fifo_push;
  fifo_entry_t         head;
  fifo_entry_t         wr_entry;
  logic                unused_addr_lsb;

  assign target          = {addr_i[31:2], 2'b00};
  assign unused_addr_lsb = ^addr_i[1:0];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Non-discarded outstanding responses will need FIFO space on return.
  always_comb begin
    nd_out = '0;
    for (int unsigned i = 0; i < NumReqs; i++) begin
      if ((OutW'(i) < out_cnt_q) && !disc_q[i]) begin
        nd_out = nd_out + OutW'(1);
      end
    end
  end

  // Request issue and address selection; a held request always wins.
  always_comb begin
    space_ok  = (SumW'(fifo_cnt_q) + SumW'(nd_out)) < SumW'(FifoDepth);
    single_ok = prefetch_en_i | branch_i | ((fifo_cnt_q == '0) & (out_cnt_q == '0));
    new_req   = run_q & req_i & (out_cnt_q < OutW'(NumReqs)) & (space_ok | branch_i) & single_ok;
    cur_tag   = hold_q & (hold_disc_q | branch_i);
  end

  assign instr_req_o   = hold_q | new_req;
  assign instr_addr_o  = hold_q ? hold_addr_q : (branch_i ? target : fetch_addr_q);
  assign gnt           = instr_req_o & instr_gnt_i;
  assign busy_o        = instr_req_o | (out_cnt_q != '0);
  assign outstanding_o = out_cnt_q;

  // Held-request and fetch-address next state.
  always_comb begin
    hold_d       = instr_req_o & ~instr_gnt_i;
    hold_addr_d  = instr_addr_o;
    hold_disc_d  = cur_tag;
    fetch_addr_d = fetch_addr_q;
    if (gnt && !cur_tag) begin
      fetch_addr_d = instr_addr_o + 32'd4;
    end else if (branch_i) begin
      fetch_addr_d = target;
    end
  end

  // In-order discard queue: bit 0 is the oldest outstanding response.
  always_comb begin
    rsp_pop    = instr_rvalid_i & (out_cnt_q != '0);
    rsp_accept = rsp_pop & ~disc_q[0] & ~branch_i;
    disc_d     = disc_q | {NumReqs{branch_i}};
    if (rsp_pop) begin
      disc_d = disc_d >> 1;
    end
    push_idx = out_cnt_q - OutW'(rsp_pop);
    if (gnt) begin
      for (int unsigned i = 0; i < NumReqs; i++) begin
        if (OutW'(i) == push_idx) begin
          disc_d[i] = cur_tag;
        end
      end
    end
    out_cnt_d = out_cnt_q + OutW'(gnt) - OutW'(rsp_pop);
  end

  // Output FIFO control; a redirect flushes everything queued.
  always_comb begin
    fifo_pop   = valid_o & ready_i;
    fifo_push  = rsp_accept & ((fifo_cnt_q != CntW'(FifoDepth)) | fifo_pop);
    fifo_cnt_d = fifo_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    rsp_addr_d = rsp_addr_q;
    wr_entry   = '{rdata: instr_rdata_i, err: instr_err_i, addr: rsp_addr_q};
    if (branch_i) begin
      fifo_cnt_d = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      rsp_addr_d = target;
    end else begin
      if (fifo_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (fifo_push) begin
        wr_ptr_d   = ptr_inc(wr_ptr_q);
        rsp_addr_d = rsp_addr_q + 32'd4;
      end
      fifo_cnt_d = fifo_cnt_q + CntW'(fifo_push) - CntW'(fifo_pop);
    end
  end

  always_comb begin
    head = '0;
    for (int unsigned i = 0; i < FifoDepth; i++) begin
      if (rd_ptr_q == PtrW'(i)) begin
        head = mem_q[i];
      end
    end
  end

  assign valid_o = (fifo_cnt_q != '0);
  assign rdata_o = head.rdata;
  assign err_o   = head.err;
  assign addr_o  = head.addr;

  // Control state, always reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q       <= 1'b0;
      hold_q      <= 1'b0;
      hold_disc_q <= 1'b0;
      out_cnt_q   <= '0;
      disc_q      <= '0;
      fifo_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      run_q       <= 1'b1;
      hold_q      <= hold_d;
      hold_disc_q <= hold_disc_d;
      out_cnt_q   <= out_cnt_d;
      disc_q      <= disc_d;
      fifo_cnt_q  <= fifo_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // Address/data state, reset only when ResetAll is set.
  if (ResetAll) begin : gen_data_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        hold_addr_q  <= '0;
        fetch_addr_q <= '0;
        rsp_addr_q   <= '0;
        for (int unsigned i = 0; i < FifoDepth; i++) begin
          mem_q[i] <= '0;
        end
      end else begin
        hold_addr_q  <= hold_addr_d;
        fetch_addr_q <= fetch_addr_d;
        rsp_addr_q   <= rsp_addr_d;
        for (int unsigned i = 0; i < FifoDepth; i++) begin
          if (fifo_push && (wr_ptr_q == PtrW'(i))) begin
            mem_q[i] <= wr_entry;
          end
        end
      end
    end
  end else begin : gen_data_norst
    always_ff @(posedge clk_i) begin
      hold_addr_q  <= hold_addr_d;
      fetch_addr_q <= fetch_addr_d;
      rsp_addr_q   <= rsp_addr_d;
      for (int unsigned i = 0; i < FifoDepth; i++) begin
        if (fifo_push && (wr_ptr_q == PtrW'(i))) begin
          mem_q[i] <= wr_entry;
        end
      end
    end
  end

endmodule
